tube_event_recorder: RTL

TUBE_EVENT_RECORDER -- requirements
Module: tube_event_recorder

---
 rtl/tube_event_recorder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tube_event_recorder.sv
// tube_event_recorder: triggered drift-tube hit recorder with header/hit words queued in a FIFO
module tube_event_recorder #(
  parameter int NUM_TUBES = 32,
  parameter int TIME_W    = 8,
  parameter int WINDOW    = 200,
  parameter int DEPTH     = 16
) (
  input  logic                 clk100,
  input  logic                 rst_n,
  input  logic                 SCIN_COIN,
  input  logic [NUM_TUBES-1:0] TUBES,
  input  logic                 RD_EN,
  output logic [15:0]          OTUBE,
  output logic                 RD_EMPTY,
  output logic                 RD_VALID,
  output logic                 BUSY,
  output logic                 overflowLight
);
  localparam int IDX_W = $clog2(NUM_TUBES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [TIME_W-1:0] T_LAST   = TIME_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]  I_LAST   = IDX_W'(NUM_TUBES - 1);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACQ, HDR, SCAN} state_t;

  state_t                   state, nxt;
  logic [NUM_TUBES:0]       s1, s2, s3;
  logic [NUM_TUBES:0]       pulse;
  logic                     coin_p;
  logic [NUM_TUBES-1:0]     tube_p;
  logic [TIME_W-1:0]        timer, t_now;
  logic                     start, acq, last;
  logic [IDX_W-1:0]         idx;
  logic [14:0]              evn;
  logic [NUM_TUBES-1:0]     hit;
  logic [TIME_W-1:0]        tm [NUM_TUBES];
  logic                     push;
  logic [15:0]              push_word, scan_word;
  logic [15:0]              mem [DEPTH];
  logic [AW-1:0]            wp, rp;
  logic [AW:0]              cnt;
  logic                     full, do_push, do_pop;

  assign pulse  = s2 & ~s3;
  assign coin_p = pulse[NUM_TUBES];
  assign tube_p = pulse[NUM_TUBES-1:0];
  // The trigger pulse cycle itself is timer value 0, even though the state is still IDLE.
  assign start  = (state == IDLE) && coin_p;
  assign acq    = start || (state == ACQ);
  assign t_now  = (state == IDLE) ? '0 : timer;
  assign last   = t_now == T_LAST;
  assign full   = cnt == FULL_CNT;
  assign do_push = push && !full;
  assign do_pop  = RD_EN && (cnt != '0);
  assign RD_EMPTY = cnt == '0;
  assign BUSY     = state != IDLE;

  // Two-flop synchroniser plus edge-detect stage for the trigger and all tubes alike.
  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {SCIN_COIN, TUBES};
      s2 <= s1;
      s3 <= s2;
    end

  // Hit word for the tube currently being scanned.
  always_comb begin
    scan_word = '0;
    scan_word[IDX_W+TIME_W-1:TIME_W] = idx;
    scan_word[TIME_W-1:0] = tm[idx];
  end

  // Next-state and FIFO push request.
  always_comb begin
    nxt = state;
    push = 1'b0;
    push_word = scan_word;
    case (state)
      IDLE: nxt = coin_p ? (last ? HDR : ACQ) : IDLE;
      ACQ:  nxt = last ? HDR : ACQ;
      HDR: begin
        nxt = SCAN;
        push = 1'b1;
        push_word = {1'b1, evn};
      end
      SCAN: begin
        nxt = (idx == I_LAST) ? IDLE : SCAN;
        push = hit[idx];
      end
      default: nxt = IDLE;
    endcase
  end

  // State register, window timer, scan index and event number.
  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      evn <= '0;
    end else begin
      state <= nxt;
      if (acq) timer <= start ? TIME_W'(1) : timer + 1'b1;
      idx <= (state == SCAN) ? idx + 1'b1 : '0;
      if (state == HDR) evn <= evn + 1'b1;
    end

  // First-edge hit latches; the trigger cycle clears them and may record time 0.
  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      hit <= '0;
      for (int i = 0; i < NUM_TUBES; i++) tm[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TUBES; i++)
        if (acq && tube_p[i] && (start || !hit[i])) begin
          hit[i] <= 1'b1;
          tm[i] <= t_now;
        end else if (start) hit[i] <= 1'b0;
    end

  // FIFO pointers, occupancy, read port and sticky overflow.
  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      RD_VALID <= 1'b0;
      OTUBE <= '0;
      overflowLight <= 1'b0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      RD_VALID <= do_pop;
      if (do_pop) OTUBE <= mem[rp];
      overflowLight <= overflowLight || (push && full);
    end

  // FIFO storage; emptiness is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk100)
    if (do_push) mem[wp] <= push_word;
endmodule
